csb_seq: RTL and testbench

Parametrised command sequencer, successor to the fixed four-engine CSB. It pulls fixed-format command bursts from the command FIFO and decodes the layer fields. It dispatches each command to one or several of N_ENG compute engines (conv/pool) using a level start/done handshake, then raises irq when cmd_size commands have retired. New behaviour over the previous CSB:
- multi-engine masks
- NOP commands
- illegal-opcode detection
- a WAIT watchdog

---
 rtl/csb_seq.sv | 151 +++++++++++++++
 tb/tb_csb_seq.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csb_seq.sv
// csb_seq: command sequencer that fetches 4-word commands and dispatches them to compute engines
module csb_seq #(
    parameter int N_ENG = 4,
    parameter int CNT_W = 7,
    parameter int TMO_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_en,
    input  logic [CNT_W-1:0] cmd_size,
    input  logic [31:0]      cmd_data,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    output logic [N_ENG-1:0] eng_start,
    input  logic [N_ENG-1:0] eng_done,
    output logic [7:0]       op_type,
    output logic [7:0]       stride_1,
    output logic [15:0]      stride_2,
    output logic [15:0]      ich_size,
    output logic [15:0]      och_size,
    output logic [31:0]      r_addr,
    output logic [31:0]      w_addr,
    output logic             busy,
    output logic             irq,
    output logic             err
);
    typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WAIT, FINISH} state_t;
    state_t           state, state_nx;
    logic [1:0]       widx, widx_nx;
    logic [CNT_W-1:0] size_q, size_nx, cnt, cnt_nx;
    logic [N_ENG-1:0] pending, pending_nx, mask, pend_left;
    logic [TMO_W-1:0] wdog, wdog_nx;
    logic [7:0]       mask_bits;
    logic             legal, err_nx, retire;

    assign cmd_ready = state == FETCH;
    assign eng_start = pending;
    assign pend_left = pending & ~eng_done;

    // engine mask decode: NOP, one-hot engine number, or 0x80-flagged multi-engine mask
    always_comb begin
        mask_bits = {1'b0, op_type[6:0]};
        legal = op_type == 8'h00;
        mask = '0;
        for (int i = 0; i < N_ENG; i++) begin
            if (op_type == 8'(i + 1)) begin
                mask[i] = 1'b1;
                legal = 1'b1;
            end
        end
        if (op_type[7] && mask_bits != 8'h00 && (mask_bits >> N_ENG) == 8'h00) begin
            mask = mask_bits[N_ENG-1:0];
            legal = 1'b1;
        end
    end

    // next state, word index, retire counter, engine pending set, watchdog and error
    always_comb begin
        state_nx = state;
        widx_nx = widx;
        size_nx = size_q;
        cnt_nx = cnt;
        pending_nx = pending;
        wdog_nx = wdog;
        err_nx = err;
        retire = 1'b0;
        case (state)
            IDLE: if (op_en) begin
                err_nx = 1'b0;
                cnt_nx = '0;
                size_nx = cmd_size;
                widx_nx = '0;
                state_nx = cmd_size != '0 ? FETCH : FINISH;
            end
            FETCH: if (cmd_valid) begin
                widx_nx = widx + 2'd1;
                state_nx = widx == 2'd3 ? ISSUE : FETCH;
            end
            ISSUE: begin
                if (!legal) begin
                    err_nx = 1'b1;
                    state_nx = FINISH;
                end else if (mask == '0) begin
                    retire = 1'b1;
                end else begin
                    pending_nx = mask;
                    wdog_nx = '0;
                    state_nx = WAIT;
                end
            end
            WAIT: begin
                pending_nx = pend_left;
                wdog_nx = wdog + 1'b1;
                if (pend_left == '0) begin
                    retire = 1'b1;
                end else if (wdog == ~TMO_W'(1)) begin
                    err_nx = 1'b1;
                    pending_nx = '0;
                    state_nx = FINISH;
                end
            end
            FINISH: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (retire) begin
            cnt_nx = cnt + 1'b1;
            widx_nx = '0;
            state_nx = cnt_nx == size_q ? FINISH : FETCH;
        end
    end

    // control registers; busy and irq are registered copies of the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            widx <= '0;
            size_q <= '0;
            cnt <= '0;
            pending <= '0;
            wdog <= '0;
            err <= 1'b0;
            busy <= 1'b0;
            irq <= 1'b0;
        end else begin
            state <= state_nx;
            widx <= widx_nx;
            size_q <= size_nx;
            cnt <= cnt_nx;
            pending <= pending_nx;
            wdog <= wdog_nx;
            err <= err_nx;
            busy <= state_nx != IDLE;
            irq <= state_nx == FINISH;
        end
    end

    // field registers load from the word being accepted and hold otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            {stride_2, stride_1, op_type} <= '0;
            {och_size, ich_size} <= '0;
            r_addr <= '0;
            w_addr <= '0;
        end else if (cmd_ready && cmd_valid) begin
            if (widx == 2'd0) {stride_2, stride_1, op_type} <= cmd_data;
            if (widx == 2'd1) {och_size, ich_size} <= cmd_data;
            if (widx == 2'd2) r_addr <= cmd_data;
            if (widx == 2'd3) w_addr <= cmd_data;
        end
    end
endmodule

// File: tb/tb_csb_seq.sv
// tb_csb_seq: randomized self-checking bench for csb_seq against a command-level reference model
module tb_csb_seq;
    localparam int N = 4;
    localparam int CW = 7;
    localparam int TW = 4;

    typedef struct {
        logic [7:0]   op;
        logic [7:0]   s1;
        logic [15:0]  s2;
        logic [15:0]  ich;
        logic [15:0]  och;
        logic [31:0]  ra;
        logic [31:0]  wa;
        logic [N-1:0] mask;
    } cmd_t;

    logic          clk = 1'b0, rst = 1'b1, op_en = 1'b0, cmd_valid = 1'b0;
    logic [CW-1:0] cmd_size = '0;
    logic [31:0]   cmd_data = '0;
    logic [N-1:0]  eng_done = '0;
    logic          cmd_ready, busy, irq, err;
    logic [N-1:0]  eng_start;
    logic [7:0]    op_type, stride_1;
    logic [15:0]   stride_2, ich_size, och_size;
    logic [31:0]   r_addr, w_addr;

    csb_seq #(.N_ENG(N), .CNT_W(CW), .TMO_W(TW)) dut (
        .clk(clk), .rst(rst), .op_en(op_en), .cmd_size(cmd_size),
        .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .eng_start(eng_start), .eng_done(eng_done), .op_type(op_type),
        .stride_1(stride_1), .stride_2(stride_2), .ich_size(ich_size),
        .och_size(och_size), .r_addr(r_addr), .w_addr(w_addr),
        .busy(busy), .irq(irq), .err(err)
    );

    initial forever #5 clk = ~clk;

    logic [31:0]  fifo[$];
    cmd_t         cmds[$];
    cmd_t         exp_disp[$];
    cmd_t         c;
    int           n_chk = 0, n_pass = 0;
    int           t = 0, words_taken, irq_cnt, exp_words, stall, gap;
    logic         gap_rand, auto_eng, exp_err;
    int           cd[N];
    logic         clr_pend[N];
    logic [N-1:0] prev_start = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0d)", tag, got, exp, t);
    endtask

    function automatic logic [N:0] ref_mask(input logic [7:0] op);
        int v = int'(op);
        if (v == 0) return {1'b1, N'(0)};
        if (v <= N) return {1'b1, N'(1 << (v - 1))};
        if (v > 128 && v < 128 + (1 << N)) return {1'b1, N'(v - 128)};
        return '0;
    endfunction

    function automatic cmd_t mk(input logic [7:0] op);
        cmd_t r;
        r.op = op;
        r.s1 = 8'($urandom);
        r.s2 = 16'($urandom);
        r.ich = 16'($urandom);
        r.och = 16'($urandom);
        r.ra = $urandom;
        r.wa = $urandom;
        r.mask = '0;
        return r;
    endfunction

    function automatic logic [7:0] rnd_op();
        int r = $urandom_range(0, 9);
        if (r == 0) return 8'h00;
        if (r < 5 || r == 9) return 8'($urandom_range(1, N));
        if (r < 8) return 8'h80 | 8'($urandom_range(1, 15));
        r = $urandom_range(0, 2);
        if (r == 0) return 8'($urandom_range(5, 127));
        if (r == 1) return 8'h80;
        return 8'h80 | 8'($urandom_range(1, 7) << 4) | 8'($urandom_range(0, 15));
    endfunction

    task automatic drive();
        cmd_valid = fifo.size() > 0 && stall == 0;
        cmd_data = fifo.size() > 0 ? fifo[0] : 32'h0;
    endtask

    task automatic tick();
        logic xfer;
        cmd_t e;
        xfer = cmd_valid && cmd_ready;
        @(posedge clk);
        #1;
        t++;
        if (xfer) begin
            void'(fifo.pop_front());
            words_taken++;
            stall = gap_rand ? $urandom_range(0, gap) : gap;
        end else if (stall > 0) stall--;
        drive();
        if (irq) irq_cnt++;
        if (prev_start == '0 && eng_start != '0) begin
            if (exp_disp.size() == 0) chk("disp_extra", 32'(eng_start), 0);
            else begin
                e = exp_disp.pop_front();
                chk("disp_mask", 32'(eng_start), 32'(e.mask));
                chk("disp_op", 32'(op_type), 32'(e.op));
                chk("disp_s1", 32'(stride_1), 32'(e.s1));
                chk("disp_s2", 32'(stride_2), 32'(e.s2));
                chk("disp_ich", 32'(ich_size), 32'(e.ich));
                chk("disp_och", 32'(och_size), 32'(e.och));
                chk("disp_ra", r_addr, e.ra);
                chk("disp_wa", w_addr, e.wa);
            end
        end
        prev_start = eng_start;
        op_en = auto_eng && busy && ($urandom_range(0, 15) == 0);
        if (op_en) cmd_size = CW'($urandom);
        for (int i = 0; i < N; i++) begin
            if (clr_pend[i]) begin
                chk("done_clr", 32'(eng_start[i]), 0);
                clr_pend[i] = 1'b0;
            end
            eng_done[i] = 1'b0;
            if (auto_eng) begin
                if (cd[i] < 0 && eng_start[i]) cd[i] = $urandom_range(0, 8);
                if (cd[i] == 0) begin
                    eng_done[i] = 1'b1;
                    cd[i] = -1;
                    clr_pend[i] = 1'b1;
                end else if (cd[i] > 0) cd[i]--;
                else if (!eng_start[i]) eng_done[i] = $urandom_range(0, 7) == 0;
            end
        end
    endtask

    task automatic clear_op();
        fifo.delete();
        cmds.delete();
        exp_disp.delete();
        words_taken = 0;
        irq_cnt = 0;
        exp_err = 1'b0;
        exp_words = 0;
        stall = 0;
        gap = 0;
        gap_rand = 1'b0;
        auto_eng = 1'b0;
        op_en = 1'b0;
        eng_done = '0;
        for (int i = 0; i < N; i++) begin
            cd[i] = -1;
            clr_pend[i] = 1'b0;
        end
        drive();
    endtask

    task automatic load();
        logic [N:0] r;
        logic stop = 1'b0;
        for (int k = 0; k < cmds.size(); k++) begin
            fifo.push_back({cmds[k].s2, cmds[k].s1, cmds[k].op});
            fifo.push_back({cmds[k].och, cmds[k].ich});
            fifo.push_back(cmds[k].ra);
            fifo.push_back(cmds[k].wa);
            if (!stop) begin
                r = ref_mask(cmds[k].op);
                exp_words += 4;
                if (!r[N]) begin
                    exp_err = 1'b1;
                    stop = 1'b1;
                end else if (r[N-1:0] != '0) begin
                    c = cmds[k];
                    c.mask = r[N-1:0];
                    exp_disp.push_back(c);
                end
            end
        end
        drive();
    endtask

    task automatic start(input int n);
        cmd_size = CW'(n);
        op_en = 1'b1;
        t = 0;
        tick();
        chk("err_clr", 32'(err), 0);
    endtask

    task automatic wait_irq(input int bound);
        int b = 0;
        while (irq_cnt == 0 && b < bound) begin
            tick();
            b++;
        end
        tick();
        chk("irq_pulse", 32'(irq), 0);
        chk("busy_end", 32'(busy), 0);
    endtask

    task automatic finish_op();
        chk("err", 32'(err), 32'(exp_err));
        chk("irq_cnt", irq_cnt, 1);
        chk("words", words_taken, exp_words);
        chk("disp_left", exp_disp.size(), 0);
        clear_op();
    endtask

    initial begin
        clear_op();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_irq", 32'(irq), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_ready", 32'(cmd_ready), 0);
        chk("rst_start", 32'(eng_start), 0);
        chk("rst_op", 32'(op_type), 0);
        chk("rst_waddr", w_addr, 0);

        c = mk(8'h01);
        c.s1 = 8'h0E;
        c.s2 = 16'h0038;
        cmds.push_back(c);
        load();
        start(1);
        chk("t1_ready", 32'(cmd_ready), 1);
        chk("t1_busy", 32'(busy), 1);
        while (t < 5) tick();
        chk("t1_lat", 32'(eng_start), 0);
        tick();
        chk("t1_start", 32'(eng_start), 1);
        chk("t1_s1", 32'(stride_1), 32'h0E);
        chk("t1_s2", 32'(stride_2), 32'h0038);
        while (t < 15) tick();
        eng_done = 4'b0001;
        tick();
        chk("t1_irq", 32'(irq), 1);
        chk("t1_clr", 32'(eng_start), 0);
        tick();
        chk("t1_idle", 32'(busy), 0);
        chk("t1_irq_end", 32'(irq), 0);
        finish_op();

        cmds.push_back(mk(8'h83));
        cmds.push_back(mk(8'h02));
        load();
        start(2);
        while (t < 6) tick();
        chk("t2_start", 32'(eng_start), 3);
        while (t < 10) tick();
        eng_done = 4'b0001;
        tick();
        chk("t2_part", 32'(eng_start), 2);
        while (t < 15) tick();
        eng_done = 4'b0010;
        tick();
        chk("t2_none", 32'(eng_start), 0);
        chk("t2_fetch", 32'(cmd_ready), 1);
        auto_eng = 1'b1;
        wait_irq(200);
        finish_op();

        cmds.push_back(mk(8'h02));
        cmds.push_back(mk(8'h00));
        cmds.push_back(mk(8'h04));
        gap = 3;
        load();
        start(3);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t3_stall_rdy", 32'(cmd_ready), 1);
        end
        auto_eng = 1'b1;
        wait_irq(500);
        finish_op();

        for (int k = 0; k < 2; k++) begin
            cmds.push_back(mk(k == 0 ? 8'h05 : 8'h80));
            cmds.push_back(mk(8'h01));
            load();
            start(2);
            auto_eng = 1'b1;
            wait_irq(100);
            chk("t4_ready", 32'(cmd_ready), 0);
            finish_op();
        end

        cmds.push_back(mk(8'h01));
        load();
        start(1);
        while (t < 6) tick();
        chk("t5_start", 32'(eng_start), 1);
        while (t < 20) tick();
        chk("t5_hold", 32'(eng_start), 1);
        chk("t5_err_pre", 32'(err), 0);
        tick();
        chk("t5_drop", 32'(eng_start), 0);
        chk("t5_err", 32'(err), 1);
        chk("t5_irq", 32'(irq), 1);
        exp_err = 1'b1;
        tick();
        finish_op();

        cmds.push_back(mk(8'h03));
        load();
        start(1);
        while (t < 6) tick();
        chk("t6_start", 32'(eng_start), 4);
        while (t < 8) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_eng", 32'(eng_start), 0);
        chk("t6_busy", 32'(busy), 0);
        chk("t6_irq", 32'(irq), 0);
        chk("t6_ready", 32'(cmd_ready), 0);
        chk("t6_op", 32'(op_type), 0);
        chk("t6_raddr", r_addr, 0);
        tick();
        tick();
        chk("t6_noirq", irq_cnt, 0);
        clear_op();
        cmds.push_back(mk(8'h85));
        load();
        start(1);
        auto_eng = 1'b1;
        wait_irq(100);
        finish_op();

        start(0);
        chk("t7_irq", 32'(irq), 1);
        chk("t7_busy", 32'(busy), 1);
        chk("t7_ready", 32'(cmd_ready), 0);
        tick();
        chk("t7_idle", 32'(busy), 0);
        finish_op();

        for (int k = 0; k < 127; k++) cmds.push_back(mk(8'h00));
        load();
        start(127);
        auto_eng = 1'b1;
        wait_irq(1000);
        finish_op();

        for (int k = 0; k < 30; k++) begin
            int n = $urandom_range(1, 6);
            for (int j = 0; j < n; j++) cmds.push_back(mk(rnd_op()));
            gap = $urandom_range(0, 3);
            gap_rand = 1'b1;
            load();
            start(n);
            auto_eng = 1'b1;
            wait_irq(400);
            finish_op();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
